rng: RTL and testbench

- Free-running 12-bit pseudo-random number generator for the elevator controller ASIC.
- Produces a new value every clock cycle for synthetic floor-button press traffic.
- Implemented as a maximal-length Fibonacci LFSR with a registered output.
- The sequence is fully deterministic from reset, so golden vectors (press.mem, 256 hex words) can be pre-computed.

---
 rtl/rng_pkg.sv | 16 +
 rtl/rng_lfsr_step.sv | 22 ++
 rtl/rng.sv | 36 +++
 tb/tb_rng.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared constants and types for the 12-bit elevator-traffic LFSR.
// The tap mask encodes x^12 + x^6 + x^4 + x + 1 as bits 11, 5, 3 and 0.
package rng_pkg;

   localparam int RNG_WIDTH = 12;
   localparam logic [11:0] RNG_TAP_MASK = 12'h829;
   localparam logic [11:0] RNG_DEFAULT_SEED = 12'h001;

   typedef logic [11:0] rng_word_t;

   // An all-zero seed would lock the LFSR, so it is replaced by the default.
   function automatic rng_word_t rng_safe_seed(input rng_word_t seed);
      return (seed == '0) ? RNG_DEFAULT_SEED : seed;
   endfunction

endpackage

// File: rtl/rng_lfsr_step.sv
// One combinational step of the Fibonacci LFSR: left shift, feedback into the
// LSB, and recovery to the seed if the state has been upset to all zeros.
module lfsr_step
   import rng_pkg::*;
#(
   parameter rng_word_t SEED = RNG_DEFAULT_SEED
) (
   input  rng_word_t s,
   output rng_word_t s_next
);

   logic fb;

   always_comb begin
      fb     = ^(s & RNG_TAP_MASK);
      s_next = {s[10:0], fb};
      if (s == '0) begin
         s_next = SEED;
      end
   end

endmodule

// File: rtl/rng.sv
// Free-running 12-bit pseudo-random source; randy comes straight from the
// state flops so it is glitch-free. Only WIDTH = 12 is meaningful.
module rng
   import rng_pkg::*;
#(
   parameter int        WIDTH = RNG_WIDTH,
   parameter rng_word_t SEED  = RNG_DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] randy
);

   localparam rng_word_t EFF_SEED = rng_safe_seed(SEED);

   rng_word_t state_reg;
   rng_word_t state_next;

   lfsr_step #(
      .SEED (EFF_SEED)
   ) u_step (
      .s      (state_reg),
      .s_next (state_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= EFF_SEED;
      end else begin
         state_reg <= state_next;
      end
   end

   assign randy = state_reg;

endmodule

// File: tb/tb_rng.sv
// Self-checking bench for rng: reset/first-value table, golden run and full
// period with an independent reference model, async reset and lock-up recovery.
module tb_rng;
   import rng_pkg::*;

   logic      clk;
   logic      rst;
   logic [11:0] randy;

   int n_cmp;
   int n_bad;

   rng_word_t exp_q[$];

   typedef struct {
      logic      rst;
      rng_word_t exp;
   } vec_t;

   vec_t vecs[10];

   bit seen[4096];

   rng #(
      .WIDTH (12),
      .SEED  (12'h001)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .randy (randy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model written straight from the feedback equation.
   function automatic rng_word_t model_next(input rng_word_t s);
      logic fb;
      if (s == 12'h000) return 12'h001;
      fb = s[11] ^ s[5] ^ s[3] ^ s[0];
      return {s[10:0], fb};
   endfunction

   task automatic check(input string name, input rng_word_t act, input rng_word_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: randy=%03h expected=%03h", name, act, exp);
      end
   endtask

   // Push the expected value, clock once, then pop and compare 2 ns after the edge.
   task automatic step_expect(input string name, input rng_word_t exp);
      rng_word_t e;
      exp_q.push_back(exp);
      @(posedge clk);
      #2;
      e = exp_q.pop_front();
      check(name, randy, e);
   endtask

   initial begin
      rng_word_t m;
      bit        zero_seen;
      bit        repeat_seen;

      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;

      vecs[0] = '{1'b1, 12'h001};
      vecs[1] = '{1'b1, 12'h001};
      vecs[2] = '{1'b1, 12'h001};
      vecs[3] = '{1'b0, 12'h003};
      vecs[4] = '{1'b0, 12'h007};
      vecs[5] = '{1'b0, 12'h00F};
      vecs[6] = '{1'b0, 12'h01E};
      vecs[7] = '{1'b0, 12'h03D};
      vecs[8] = '{1'b0, 12'h07B};
      vecs[9] = '{1'b0, 12'h0F7};

      #3;
      check("reset_value", randy, 12'h001);

      // Inputs change 2 ns after a rising edge, well clear of the next one.
      for (int i = 0; i < 10; i++) begin
         rst = vecs[i].rst;
         step_expect($sformatf("vec%0d", i), vecs[i].exp);
         $display("vec %0d: rst=%0b randy=%03h expected=%03h", i, vecs[i].rst, randy, vecs[i].exp);
      end

      // Golden run and full period from a fresh async reset.
      rst = 1'b1;
      #1;
      check("golden_reset", randy, 12'h001);
      rst = 1'b0;
      m = 12'h001;
      for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
      seen[12'h001] = 1'b1;
      zero_seen   = 1'b0;
      repeat_seen = 1'b0;
      for (int k = 1; k <= 4095; k++) begin
         m = model_next(m);
         step_expect($sformatf("seq%0d", k), m);
         if (k <= 255) $display("golden %0d: randy=%03h expected=%03h", k, randy, m);
         if (randy == 12'h000) zero_seen = 1'b1;
         if (k < 4095) begin
            if (seen[randy]) repeat_seen = 1'b1;
            seen[randy] = 1'b1;
         end
      end
      check("period_return", randy, 12'h001);
      n_cmp++;
      if (zero_seen || repeat_seen) begin
         n_bad++;
         $display("FAIL period_coverage: zero=%0b repeat=%0b expected zero=0 repeat=0", zero_seen, repeat_seen);
      end
      $display("period: randy=%03h after 4095 edges zero=%0b repeat=%0b", randy, zero_seen, repeat_seen);

      // Run ~100 cycles, then pulse reset between edges.
      m = 12'h001;
      for (int k = 1; k <= 100; k++) begin
         m = model_next(m);
         step_expect($sformatf("pre_rst%0d", k), m);
      end
      rst = 1'b1;
      #1;
      check("async_reset", randy, 12'h001);
      $display("async reset: randy=%03h expected=001", randy);
      #1;
      rst = 1'b0;
      step_expect("after_rst_1", 12'h003);
      step_expect("after_rst_2", 12'h007);
      step_expect("after_rst_3", 12'h00F);

      // Upset the state to zero and confirm recovery on the next edge.
      force dut.state_reg = 12'h000;
      #1;
      check("forced_zero", randy, 12'h000);
      release dut.state_reg;
      #1;
      step_expect("lockup_1", 12'h001);
      step_expect("lockup_2", 12'h003);
      step_expect("lockup_3", 12'h007);
      $display("lock-up recovery: randy=%03h expected=007", randy);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
